// File: rtl/sm_add_arbiter_if.sv
// Requester/consumer bundle for the shared sign-magnitude adder arbiter.
// The arbiter takes the slave side; clients and the consumer take the master side.
interface sm_add_arbiter_if #(
  parameter int WIDTH = 15,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH:0]        out_data;
  logic [IDW-1:0]        out_id;
  logic                  busy;

  modport slave (
    input  req_valid, req_a, req_b, out_ready,
    output req_ready, out_valid, out_data, out_id, busy
  );

  modport master (
    output req_valid, req_a, req_b, out_ready,
    input  req_ready, out_valid, out_data, out_id, busy
  );
endinterface

// File: rtl/sm_add_arbiter.sv
// Round-robin arbiter sharing one sign-magnitude adder between NREQ requesters.
// Flow per operation: grant/capture in IDLE, add in CALC, hold tagged result in HOLD.
module sm_add_arbiter #(
  parameter int WIDTH = 15,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic            clk,
  input  logic            rst,
  sm_add_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH:0]   out_data_q, out_data_d;
  logic [IDW-1:0]   out_id_q, out_id_d;

  logic             found;
  logic [IDW-1:0]   win;
  logic [IDW:0]     cand;
  logic [NREQ-1:0]  grant;

  logic [WIDTH-2:0] ma, mb;
  logic             sa, sb;
  logic             sum_sign;
  logic [WIDTH-1:0] sum_mag;
  logic [WIDTH:0]   sum;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!found && bus.req_valid[cand[IDW-1:0]]) begin
        found = 1'b1;
        win   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    ma       = a_q[WIDTH-2:0];
    mb       = b_q[WIDTH-2:0];
    sa       = a_q[WIDTH-1];
    sb       = b_q[WIDTH-1];
    sum_sign = 1'b0;
    sum_mag  = '0;
    if (sa == sb) begin
      sum_mag  = {1'b0, ma} + {1'b0, mb};
      sum_sign = sa;
    end else if (ma > mb) begin
      sum_mag  = {1'b0, ma - mb};
      sum_sign = sa;
    end else if (mb > ma) begin
      sum_mag  = {1'b0, mb - ma};
      sum_sign = sb;
    end
    // Opposite signs with equal magnitudes fall through to positive zero.
    sum = {sum_sign, sum_mag};
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    grant       = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant[win] = 1'b1;
          a_d        = bus.req_a[int'(win)*WIDTH +: WIDTH];
          b_d        = bus.req_b[int'(win)*WIDTH +: WIDTH];
          id_d       = win;
          rr_ptr_d   = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
          state_d    = CALC;
        end
      end
      CALC: begin
        out_data_d  = sum;
        out_id_d    = id_q;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  // A grant in the reset cycle would be a lost handshake, so reset masks it.
  assign bus.req_ready = rst ? '0 : grant;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sm_add_arbiter.sv
// Directed and randomized checks of sm_add_arbiter against a value-level adder
// model and a pointer-based round-robin model.
module tb_sm_add_arbiter;
  localparam int W = 15;
  localparam int N = 4;
  localparam int I = 2;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   rr_m;

  logic [N-1:0] valid_m;
  logic [W-1:0] a_m [N];
  logic [W-1:0] b_m [N];
  logic         out_ready_m;

  sm_add_arbiter_if #(.WIDTH(W), .NREQ(N), .IDW(I)) bus ();

  sm_add_arbiter #(.WIDTH(W), .NREQ(N), .IDW(I)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Sign-magnitude sum computed as signed integer arithmetic.
  function automatic logic [W:0] smAdd(input logic [W-1:0] a, input logic [W-1:0] b);
    int va, vb, s;
    va = int'(a[W-2:0]);
    vb = int'(b[W-2:0]);
    if (a[W-1]) va = -va;
    if (b[W-1]) vb = -vb;
    s = va + vb;
    if (s == 0) return (a[W-1] == b[W-1]) ? {a[W-1], W'(0)} : '0;
    if (s < 0) return {1'b1, W'(-s)};
    return {1'b0, W'(s)};
  endfunction

  function automatic int modelGrant();
    for (int k = 0; k < N; k++) begin
      if (valid_m[(rr_m + k) % N]) return (rr_m + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] randOperand();
    return W'($urandom);
  endfunction

  task automatic applyStimulus();
    bus.req_valid = valid_m;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = a_m[i];
      bus.req_b[i*W +: W] = b_m[i];
    end
    bus.out_ready = out_ready_m;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One operation from grant to accept, starting in an IDLE cycle.
  task automatic runTransaction(input string tag, input int hold, input bit refill,
                                input logic [N-1:0] late_mask);
    int             g;
    logic [W:0]     exp_d;
    logic [I-1:0]   exp_id;
    g = modelGrant();
    applyStimulus();
    #1;
    checkOutput({tag, "_ready"}, 32'(bus.req_ready), (g < 0) ? 0 : (1 << g));
    if (g < 0) begin
      @(posedge clk); #1;
      return;
    end
    exp_d  = smAdd(a_m[g], b_m[g]);
    exp_id = I'(g);
    rr_m   = (g + 1) % N;
    if (refill) begin
      a_m[g] = randOperand();
      b_m[g] = randOperand();
    end else begin
      valid_m[g] = 1'b0;
    end
    @(posedge clk); #1;
    valid_m = valid_m | late_mask;
    applyStimulus();
    #1;
    checkOutput({tag, "_calc_busy"}, 32'(bus.busy), 1);
    checkOutput({tag, "_calc_valid"}, 32'(bus.out_valid), 0);
    checkOutput({tag, "_calc_ready"}, 32'(bus.req_ready), 0);
    @(posedge clk); #1;
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 1);
    checkOutput({tag, "_data"}, 32'(bus.out_data), 32'(exp_d));
    checkOutput({tag, "_id"}, 32'(bus.out_id), 32'(exp_id));
    checkOutput({tag, "_hold_ready"}, 32'(bus.req_ready), 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkOutput({tag, "_bp_valid"}, 32'(bus.out_valid), 1);
      checkOutput({tag, "_bp_data"}, 32'(bus.out_data), 32'(exp_d));
      checkOutput({tag, "_bp_id"}, 32'(bus.out_id), 32'(exp_id));
      checkOutput({tag, "_bp_ready"}, 32'(bus.req_ready), 0);
    end
    out_ready_m = 1'b1;
    applyStimulus();
    @(posedge clk); #1;
    out_ready_m = 1'b0;
    applyStimulus();
  endtask

  initial begin
    valid_m     = '0;
    out_ready_m = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_m[i] = '0;
      b_m[i] = '0;
    end
    rst = 1'b1;
    applyStimulus();

    // Reset wins over simultaneous requests.
    @(posedge clk); #1;
    valid_m = 4'b1111;
    applyStimulus();
    #1;
    checkOutput("rst_ready", 32'(bus.req_ready), 0);
    @(posedge clk); #1;
    checkOutput("rst_ready2", 32'(bus.req_ready), 0);
    valid_m = '0;
    rst     = 1'b0;
    applyStimulus();
    #1;
    checkOutput("rst_valid", 32'(bus.out_valid), 0);
    checkOutput("rst_busy", 32'(bus.busy), 0);
    checkOutput("rst_data", 32'(bus.out_data), 0);
    checkOutput("rst_id", 32'(bus.out_id), 0);
    rr_m = 0;

    valid_m = 4'b0001; a_m[0] = 15'h0064; b_m[0] = 15'h401E;
    runTransaction("mix_a", 0, 1'b0, '0);
    valid_m = 4'b0100; a_m[2] = 15'h401E; b_m[2] = 15'h0064;
    runTransaction("mix_b", 0, 1'b0, '0);
    valid_m = 4'b0100; a_m[2] = 15'h0005; b_m[2] = 15'h4005;
    runTransaction("cancel", 0, 1'b0, '0);
    valid_m = 4'b1000; a_m[3] = 15'h7FFF; b_m[3] = 15'h4001;
    runTransaction("carry", 0, 1'b0, '0);

    // All requesters valid: refill for one full lap, then drain.
    valid_m = 4'b1111;
    for (int i = 0; i < N; i++) begin
      a_m[i] = randOperand();
      b_m[i] = randOperand();
    end
    for (int r = 0; r < 2 * N; r++) runTransaction("rot", 0, (r < N), '0);

    valid_m = 4'b0001; a_m[0] = 15'h0123; b_m[0] = 15'h0011;
    a_m[1] = 15'h4010; b_m[1] = 15'h4020;
    runTransaction("bp", 10, 1'b0, 4'b0010);
    runTransaction("bp_next", 0, 1'b0, '0);

    // Reset during CALC.
    valid_m = 4'b0100; a_m[2] = 15'd1000; b_m[2] = 15'd2000;
    applyStimulus();
    #1;
    checkOutput("mid_calc_grant", 32'(bus.req_ready), 32'h4);
    @(posedge clk); #1;
    valid_m = '0;
    rst     = 1'b1;
    applyStimulus();
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("mid_calc_valid", 32'(bus.out_valid), 0);
    checkOutput("mid_calc_busy", 32'(bus.busy), 0);
    checkOutput("mid_calc_data", 32'(bus.out_data), 0);
    @(posedge clk); #1;
    checkOutput("mid_calc_nopulse", 32'(bus.out_valid), 0);
    rr_m = 0;

    // Reset during HOLD.
    valid_m = 4'b0010; a_m[1] = 15'h0100; b_m[1] = 15'h0200;
    applyStimulus();
    #1;
    checkOutput("mid_hold_grant", 32'(bus.req_ready), 32'h2);
    @(posedge clk); #1;
    valid_m = '0;
    applyStimulus();
    @(posedge clk); #1;
    checkOutput("mid_hold_data_pre", 32'(bus.out_data), 32'h0300);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("mid_hold_valid", 32'(bus.out_valid), 0);
    checkOutput("mid_hold_busy", 32'(bus.busy), 0);
    checkOutput("mid_hold_data", 32'(bus.out_data), 0);
    checkOutput("mid_hold_id", 32'(bus.out_id), 0);
    rr_m = 0;

    valid_m = 4'b1111;
    for (int i = 0; i < N; i++) begin
      a_m[i] = randOperand();
      b_m[i] = randOperand();
    end
    runTransaction("post_rst", 0, 1'b0, '0);

    // Random arrivals, operands and back-pressure.
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!valid_m[i] && ($urandom_range(0, 1) == 1)) begin
          valid_m[i] = 1'b1;
          a_m[i]     = randOperand();
          b_m[i]     = randOperand();
          if ($urandom_range(0, 3) == 0) b_m[i] = {~a_m[i][W-1], a_m[i][W-2:0]};
        end
      end
      if (valid_m == '0) begin
        valid_m[0] = 1'b1;
        a_m[0]     = randOperand();
        b_m[0]     = randOperand();
      end
      runTransaction("rand", int'($urandom_range(0, 3)), 1'b0, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
